// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end:
// opcode encodings, the NOP filler word and the fetch FSM states.
package instruction_fetch_unit_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // Bit 7 set means the decoder performs no register write.
  localparam logic [7:0] NOP_WORD = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  function automatic logic is_halt(input logic [7:0] word);
    return word[7:6] == OP_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_mem.sv
// Programmable instruction store: register array with a synchronous
// write port and a combinational read port. Every word resets to NOP.
module instr_mem
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM, program counter and IF/ID register. Issues one word per
// unstalled cycle and parks on a HALT word without issuing it.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic            start,
  input  logic            stall,
  output logic [7:0]      Instruction_Code,
  output logic            Instr_Valid,
  output logic [PC_W-1:0] PC,
  output logic            halted
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [7:0]      ic_q, ic_n;
  logic            vld_q, vld_n;
  logic [7:0]      rd_word;
  logic            mem_we;

  // Writes are locked out while fetching, so reads never race a write.
  assign mem_we = prog_we && (state != FETCH);

  instr_mem #(.DEPTH(DEPTH), .AW(PC_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
      ic_q  <= NOP_WORD;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      ic_q  <= ic_n;
      vld_q <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ic_n    = ic_q;
    vld_n   = vld_q;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_n    = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        // Stall outranks halt detection.
        if (!stall) begin
          if (is_halt(rd_word)) begin
            ic_n    = NOP_WORD;
            vld_n   = 1'b0;
            state_n = HALTED;
          end else begin
            ic_n  = rd_word;
            vld_n = 1'b1;
            pc_n  = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pc_n    = '0;
        ic_n    = NOP_WORD;
        vld_n   = 1'b0;
      end
    endcase
  end

  assign Instruction_Code = ic_q;
  assign Instr_Valid      = vld_q;
  assign PC               = pc_q;
  assign halted           = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, basic run, stall,
// PC wrap, write lockout during fetch and restart from HALTED.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       stall;
  logic [7:0] Instruction_Code;
  logic       Instr_Valid;
  logic [3:0] PC;
  logic       halted;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit #(.DEPTH(16), .PC_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .start            (start),
    .stall            (stall),
    .Instruction_Code (Instruction_Code),
    .Instr_Valid      (Instr_Valid),
    .PC               (PC),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic prog_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start sampled at the next posedge; returns at the negedge after it.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (Instruction_Code !== 8'h80 || Instr_Valid !== 1'b0 || PC !== 4'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ic=%h v=%b pc=%0d h=%b want 80/0/0/0", Instruction_Code, Instr_Valid, PC, halted);
    end
    // Memory resets to NOP, which issues as a valid word.
    pulse_start();
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h80 || Instr_Valid !== 1'b1 || PC !== 4'd1) begin
      failures++;
      $display("FAIL reset_mem_nop: ic=%h v=%b pc=%0d want 80/1/1", Instruction_Code, Instr_Valid, PC);
    end
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (Instruction_Code !== 8'h80 || Instr_Valid !== 1'b0 || PC !== 4'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: ic=%h v=%b pc=%0d h=%b want 80/0/0/0", Instruction_Code, Instr_Valid, PC, halted);
    end
    @(negedge clk);
    reset = 1'b0;
    // IDLE: no issue without start.
    repeat (2) @(negedge clk);
    checks++;
    if (Instr_Valid !== 1'b0 || PC !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: v=%b pc=%0d want 0/0", Instr_Valid, PC);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    prog_word(4'd0, 8'h0A);
    prog_word(4'd1, 8'h51);
    prog_word(4'd2, 8'hC0);
    pulse_start();
    checks++;
    if (Instruction_Code !== 8'h80 || Instr_Valid !== 1'b0 || PC !== 4'd0) begin
      failures++;
      $display("FAIL basic_latency: ic=%h v=%b pc=%0d want 80/0/0", Instruction_Code, Instr_Valid, PC);
    end
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h0A || Instr_Valid !== 1'b1 || PC !== 4'd1) begin
      failures++;
      $display("FAIL basic_i0: ic=%h v=%b pc=%0d want 0A/1/1", Instruction_Code, Instr_Valid, PC);
    end
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h51 || Instr_Valid !== 1'b1 || PC !== 4'd2) begin
      failures++;
      $display("FAIL basic_i1: ic=%h v=%b pc=%0d want 51/1/2", Instruction_Code, Instr_Valid, PC);
    end
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h80 || Instr_Valid !== 1'b0 || halted !== 1'b1 || PC !== 4'd2) begin
      failures++;
      $display("FAIL basic_halt: ic=%h v=%b h=%b pc=%0d want 80/0/1/2", Instruction_Code, Instr_Valid, halted, PC);
    end
    // HALTED ignores stall and holds.
    stall = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b0;
    checks++;
    if (Instr_Valid !== 1'b0 || halted !== 1'b1 || PC !== 4'd2) begin
      failures++;
      $display("FAIL basic_halt_hold: v=%b h=%b pc=%0d want 0/1/2", Instr_Valid, halted, PC);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    prog_word(4'd0, 8'h0A);
    prog_word(4'd1, 8'h51);
    prog_word(4'd2, 8'hC0);
    pulse_start();
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (Instruction_Code !== 8'h0A || Instr_Valid !== 1'b1 || PC !== 4'd1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: ic=%h v=%b pc=%0d want 0A/1/1", i, Instruction_Code, Instr_Valid, PC);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h51 || Instr_Valid !== 1'b1 || PC !== 4'd2) begin
      failures++;
      $display("FAIL stall_resume: ic=%h v=%b pc=%0d want 51/1/2", Instruction_Code, Instr_Valid, PC);
    end
    // Stall while the HALT word is at PC suppresses halt detection.
    stall = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b0 || Instruction_Code !== 8'h51 || PC !== 4'd2) begin
      failures++;
      $display("FAIL stall_over_halt: h=%b ic=%h pc=%0d want 0/51/2", halted, Instruction_Code, PC);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || Instr_Valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_then_halt: h=%b v=%b want 1/0", halted, Instr_Valid);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc;
    apply_reset();
    for (int a = 0; a < 16; a++) prog_word(4'(a), 8'h09);
    pulse_start();
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      exp_pc = 4'(k);
      checks++;
      if (Instruction_Code !== 8'h09 || Instr_Valid !== 1'b1 || PC !== exp_pc) begin
        failures++;
        $display("FAIL wrap[%0d]: ic=%h v=%b pc=%0d want 09/1/%0d", k, Instruction_Code, Instr_Valid, PC, exp_pc);
      end
    end
  endtask

  task automatic test_lockout();
    logic [7:0] exp_words [0:4];
    exp_words = '{8'h01, 8'h42, 8'h03, 8'h44, 8'h05};
    apply_reset();
    for (int a = 0; a < 5; a++) prog_word(4'(a), exp_words[a]);
    prog_word(4'd5, 8'hC0);
    pulse_start();
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (Instruction_Code !== exp_words[k] || Instr_Valid !== 1'b1) begin
        failures++;
        $display("FAIL lockout[%0d]: ic=%h v=%b want %h/1", k, Instruction_Code, Instr_Valid, exp_words[k]);
      end
    end
    prog_we = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || PC !== 4'd5) begin
      failures++;
      $display("FAIL lockout_halt: h=%b pc=%0d want 1/5", halted, PC);
    end
  endtask

  task automatic test_restart();
    int budget;
    apply_reset();
    prog_word(4'd0, 8'h0A);
    prog_word(4'd1, 8'hC0);
    pulse_start();
    budget = 0;
    while (halted !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL restart_wait_halt: h=%b after %0d cycles want 1", halted, budget);
    end
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h12; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    checks++;
    if (halted !== 1'b0 || PC !== 4'd0 || Instr_Valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_edge: h=%b pc=%0d v=%b want 0/0/0", halted, PC, Instr_Valid);
    end
    @(negedge clk);
    checks++;
    if (Instruction_Code !== 8'h12 || Instr_Valid !== 1'b1 || PC !== 4'd1) begin
      failures++;
      $display("FAIL restart_first: ic=%h v=%b pc=%0d want 12/1/1", Instruction_Code, Instr_Valid, PC);
    end
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; stall = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_lockout();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the pipeline that supplies the 8-bit Instruction_Code consumed by the main control unit.
- Holds a small programmable instruction memory and a program counter.
- Issues one instruction per cycle into the IF/ID register, with stall support.
- Detects HALT and stops issue.
- Instruction word: [7:6] opcode (00 add, 01 sll, 10 nop, 11 halt), [5:3] rd, [2:0] rs/shamt.

Parameters:
- DEPTH, 16, number of instruction memory words (power of two).
- PC_W, 4, program counter width, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  write strobe for the instruction memory; honoured only in IDLE or HALTED.
- prog_addr  in  PC_W  memory write address.
- prog_data  in  8  memory write data.
- start  in  1  single-cycle pulse; begins execution at PC=0 from IDLE or HALTED.
- stall  in  1  pipeline stall; freezes PC and the IF/ID outputs.
- Instruction_Code  out  8  IF/ID instruction register.
- Instr_Valid  out  1  Instruction_Code holds a real issued instruction.
- PC  out  PC_W  address of the next word to fetch.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-fetch):
  - state=IDLE, PC=0, Instruction_Code=8'h80 (NOP, bit7=1 so no register write), Instr_Valid=0, halted=0.
  - All memory words reset to 8'h80.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - prog_we writes mem[prog_addr]<=prog_data.
  - start: PC<=0, state<=FETCH. Outputs stay NOP/invalid.
  - stall is ignored.
- FETCH, stall=0, mem[PC][7:6]!=11:
  - Instruction_Code<=mem[PC], Instr_Valid<=1, PC<=PC+1.
  - PC wraps from DEPTH-1 to 0 and execution continues.
- FETCH, stall=0, mem[PC][7:6]==11 (HALT):
  - HALT is not issued: Instruction_Code<=8'h80, Instr_Valid<=0.
  - PC holds the halt address; state<=HALTED; halted<=1.
- FETCH, stall=1:
  - PC, Instruction_Code and Instr_Valid hold. No halt detection.
  - Stall has priority over halt detection.
- FETCH, prog_we: ignored (no write). start: ignored.
- HALTED:
  - Outputs hold NOP/invalid; stall is ignored; prog_we is honoured.
  - start: PC<=0, halted<=0, state<=FETCH.
- Simultaneous prog_we and start in IDLE/HALTED: the write commits on the same edge. The first fetch happens on the following edge and sees the new data.
- Latency: start sampled at edge N; the first instruction appears on Instruction_Code after edge N+1; one instruction per unstalled cycle thereafter.
- Memory read is combinational from the array, registered into Instruction_Code. No read-during-write hazard exists because writes are blocked in FETCH.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=2'b00, OP_SLL=2'b01, OP_NOP=2'b10, OP_HALT=2'b11.
  - NOP_WORD=8'h80.
  - state encoding IDLE/FETCH/HALTED.
- One sub-module: instr_mem.
  - DEPTH x 8 register array.
  - Async reset to NOP_WORD, synchronous write port, combinational read port.
- The FSM, PC and IF/ID register stay in instruction_fetch_unit.

Test Plan:
- Reset check: assert reset mid-cycle while in FETCH -> immediately Instruction_Code=8'h80, Instr_Valid=0, PC=0, halted=0, state IDLE.
- Basic run: program mem[0..2]=8'h0A, 8'h51, 8'hC0, pulse start -> Instruction_Code 8'h0A then 8'h51 with Instr_Valid=1 on consecutive cycles. Next cycle: NOP, Instr_Valid=0, halted=1, PC=2.
- Stall: same program, hold stall for 3 cycles after 8'h0A issues -> 8'h0A and PC=1 hold for 3 cycles, then 8'h51 issues.
- Wrap: fill all 16 words with 8'h09 except none halt, run 18 cycles -> PC sequence wraps 15->0, Instr_Valid stays 1.
- Write lockout: prog_we to addr 3 with 8'hFF during FETCH -> mem[3] unchanged, verified when 3 issues its original word.
- Restart: in HALTED, same-cycle prog_we addr 0 = 8'h12 and start -> first issued word is 8'h12 and halted drops to 0.
